// File: rtl/npc_seq_ctrl.sv
// Multi-cycle instruction sequencer: FETCH -> EXEC -> (MEM) -> WB.
// Owns the PC, the IFU/LSU request handshakes and the single-cycle WB commit strobes.
module npc_seq_ctrl #(
  parameter logic [31:0] RESET_PC    = 32'h8000_0000,
  parameter logic [15:0] MEM_TIMEOUT = 16'd1023
) (
  input  logic        clk,
  input  logic        rst,
  output logic        ifu_req_o,
  output logic [31:0] ifu_addr_o,
  input  logic        ifu_ack_i,
  input  logic [31:0] ifu_rdata_i,
  output logic [31:0] inst_o,
  input  logic        dec_is_load_i,
  input  logic        dec_is_store_i,
  input  logic        dec_rd_we_i,
  input  logic        dec_ecall_i,
  input  logic        dec_mret_i,
  input  logic        dec_ebreak_i,
  input  logic        exu_branch_taken_i,
  input  logic [31:0] exu_branch_target_i,
  input  logic [31:0] exu_ecall_target_i,
  input  logic [31:0] exu_mret_target_i,
  output logic        lsu_req_o,
  input  logic        lsu_ack_i,
  output logic        rf_we_o,
  output logic        csr_commit_o,
  output logic [31:0] pc_o,
  output logic        halt_o,
  output logic        err_o,
  output logic [2:0]  state_o
);

  typedef enum logic [2:0] {
    S_FETCH = 3'd0,
    S_EXEC  = 3'd1,
    S_MEM   = 3'd2,
    S_WB    = 3'd3,
    S_HALT  = 3'd4,
    S_ERROR = 3'd5
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] inst_q, inst_d;
  logic [15:0] cnt_q, cnt_d;
  logic [15:0] wait_tick;
  logic        timed_out;
  logic [31:0] next_pc;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_FETCH;
      pc_q    <= RESET_PC;
      inst_q  <= 32'h0000_0013;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      inst_q  <= inst_d;
      cnt_q   <= cnt_d;
    end
  end

  // Redirect priority: trap entry, trap return, then control flow.
  always_comb begin
    next_pc = pc_q + 32'd4;
    if (dec_ecall_i)             next_pc = exu_ecall_target_i;
    else if (dec_mret_i)         next_pc = exu_mret_target_i;
    else if (exu_branch_taken_i) next_pc = exu_branch_target_i;
  end

  assign wait_tick = cnt_q + 16'd1;
  assign timed_out = (wait_tick == MEM_TIMEOUT);

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    inst_d       = inst_q;
    cnt_d        = cnt_q;
    ifu_req_o    = 1'b0;
    lsu_req_o    = 1'b0;
    rf_we_o      = 1'b0;
    csr_commit_o = 1'b0;
    case (state_q)
      S_FETCH: begin
        ifu_req_o = 1'b1;
        if (ifu_ack_i) begin
          inst_d  = ifu_rdata_i;
          state_d = S_EXEC;
        end else if (timed_out) begin
          state_d = S_ERROR;
        end else begin
          cnt_d = wait_tick;
        end
      end
      S_EXEC: begin
        if (dec_ebreak_i)                       state_d = S_HALT;
        else if (dec_is_load_i | dec_is_store_i) state_d = S_MEM;
        else                                    state_d = S_WB;
      end
      S_MEM: begin
        lsu_req_o = 1'b1;
        if (lsu_ack_i)      state_d = S_WB;
        else if (timed_out) state_d = S_ERROR;
        else                cnt_d   = wait_tick;
      end
      S_WB: begin
        rf_we_o      = dec_rd_we_i & ~dec_ecall_i;
        csr_commit_o = 1'b1;
        if (next_pc[1:0] != 2'b00) begin
          state_d = S_ERROR;
        end else begin
          pc_d    = next_pc;
          state_d = S_FETCH;
        end
      end
      S_HALT:  state_d = S_HALT;
      S_ERROR: state_d = S_ERROR;
      default: state_d = S_ERROR;
    endcase
    // Wait counter restarts on every state entry.
    if (state_d != state_q) cnt_d = '0;
  end

  assign ifu_addr_o = pc_q;
  assign inst_o     = inst_q;
  assign pc_o       = pc_q;
  assign halt_o     = (state_q == S_HALT);
  assign err_o      = (state_q == S_ERROR);
  assign state_o    = state_q;

endmodule

// File: tb/tb_npc_seq_ctrl.sv
// Directed self-checking bench for npc_seq_ctrl (MEM_TIMEOUT overridden to 8).
module tb_npc_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        ifu_req, ifu_ack, lsu_req, lsu_ack;
  logic [31:0] ifu_addr, ifu_rdata, inst;
  logic        dec_is_load, dec_is_store, dec_rd_we, dec_ecall, dec_mret, dec_ebreak;
  logic        br_taken;
  logic [31:0] br_target, ecall_target, mret_target;
  logic        rf_we, csr_commit, halt, err;
  logic [31:0] pc;
  logic [2:0]  state;

  int checks = 0;
  int passed = 0;
  int n;

  always #5 clk = ~clk;

  npc_seq_ctrl #(.RESET_PC(32'h8000_0000), .MEM_TIMEOUT(16'd8)) dut (
    .clk(clk), .rst(rst),
    .ifu_req_o(ifu_req), .ifu_addr_o(ifu_addr), .ifu_ack_i(ifu_ack), .ifu_rdata_i(ifu_rdata),
    .inst_o(inst),
    .dec_is_load_i(dec_is_load), .dec_is_store_i(dec_is_store), .dec_rd_we_i(dec_rd_we),
    .dec_ecall_i(dec_ecall), .dec_mret_i(dec_mret), .dec_ebreak_i(dec_ebreak),
    .exu_branch_taken_i(br_taken), .exu_branch_target_i(br_target),
    .exu_ecall_target_i(ecall_target), .exu_mret_target_i(mret_target),
    .lsu_req_o(lsu_req), .lsu_ack_i(lsu_ack),
    .rf_we_o(rf_we), .csr_commit_o(csr_commit), .pc_o(pc),
    .halt_o(halt), .err_o(err), .state_o(state)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_dec();
    dec_is_load = 0; dec_is_store = 0; dec_rd_we = 0; dec_ecall = 0;
    dec_mret = 0; dec_ebreak = 0; br_taken = 0;
  endtask

  task automatic do_reset();
    rst = 1; ifu_ack = 0; lsu_ack = 0;
    tick(); tick();
    rst = 0;
  endtask

  // Fetch with a first-cycle ack, then run EXEC and WB; leaves bench in the next FETCH.
  task automatic run_simple(input logic [31:0] word);
    ifu_ack = 1; ifu_rdata = word;
    tick();
    ifu_ack = 0;
    tick();
    tick();
  endtask

  initial begin
    ifu_rdata = 32'h0; br_target = 32'h0; ecall_target = 32'h0; mret_target = 32'h0;
    clr_dec();
    do_reset();

    // Reset state
    chk("rst_state", state, 0);
    chk("rst_pc", pc, 32'h8000_0000);
    chk("rst_inst", inst, 32'h0000_0013);
    chk("rst_flags", {halt, err, rf_we, csr_commit, lsu_req}, 0);
    chk("rst_ifu_req", ifu_req, 1);
    chk("rst_ifu_addr", ifu_addr, 32'h8000_0000);

    // addi: ack in first FETCH cycle, rf_we in cycle 3
    dec_rd_we = 1; ifu_ack = 1; ifu_rdata = 32'h0010_0093;
    chk("addi_c1_rfwe", rf_we, 0);
    tick(); ifu_ack = 0;
    chk("addi_c2_state", state, 1);
    chk("addi_c2_inst", inst, 32'h0010_0093);
    chk("addi_c2_ifureq", ifu_req, 0);
    chk("addi_c2_rfwe", rf_we, 0);
    tick();
    chk("addi_c3_state", state, 3);
    chk("addi_c3_rfwe", rf_we, 1);
    chk("addi_c3_csr", csr_commit, 1);
    tick();
    chk("addi_pc", pc, 32'h8000_0004);
    chk("addi_after_rfwe", rf_we, 0);
    chk("addi_after_state", state, 0);

    // lw with lsu_ack on the 6th MEM cycle
    dec_is_load = 1; dec_rd_we = 1; ifu_ack = 1; ifu_rdata = 32'h0000_2083;
    tick(); ifu_ack = 0;
    lsu_ack = 1;  // stray ack in EXEC must be ignored
    tick(); lsu_ack = 0;
    chk("lw_mem_state", state, 2);
    n = 0;
    for (int i = 0; i < 6; i++) begin
      lsu_ack = (i == 5);
      if (lsu_req) n++;
      if (rf_we) n += 100;
      tick();
    end
    lsu_ack = 0;
    chk("lw_req_cycles", n, 6);
    chk("lw_wb_state", state, 3);
    chk("lw_wb_rfwe", rf_we, 1);
    chk("lw_wb_lsureq", lsu_req, 0);
    tick();
    chk("lw_pc", pc, 32'h8000_0008);
    clr_dec();

    // ecall beats a taken branch; no rd write, one csr_commit pulse
    dec_ecall = 1; dec_rd_we = 1; br_taken = 1;
    br_target = 32'h8000_0200; ecall_target = 32'h8000_0100; mret_target = 32'h8000_0300;
    ifu_ack = 1;
    tick(); ifu_ack = 0;
    n = csr_commit;
    tick();
    chk("ecall_rfwe", rf_we, 0);
    n += csr_commit;
    tick();
    n += csr_commit;
    chk("ecall_csr_pulses", n, 1);
    chk("ecall_pc", pc, 32'h8000_0100);
    clr_dec();

    // mret beats a taken branch
    dec_mret = 1; br_taken = 1; mret_target = 32'h8000_0040;
    run_simple(32'h3020_0073);
    chk("mret_pc", pc, 32'h8000_0040);
    clr_dec();

    // pc + 4 wraps from 0xFFFF_FFFC to 0
    br_taken = 1; br_target = 32'hFFFF_FFFC;
    run_simple(32'h0000_006F);
    chk("br_pc", pc, 32'hFFFF_FFFC);
    clr_dec();
    run_simple(32'h0000_0013);
    chk("wrap_pc", pc, 32'h0000_0000);
    chk("wrap_state", state, 0);

    // Misaligned branch target -> ERROR, pc unchanged
    br_taken = 1; br_target = 32'h8000_0002;
    run_simple(32'h0000_006F);
    chk("mis_state", state, 5);
    chk("mis_err", err, 1);
    chk("mis_pc", pc, 32'h0000_0000);
    chk("mis_ifureq", ifu_req, 0);
    clr_dec();

    // ebreak: halt two cycles after fetch ack, then quiet for 100 cycles
    do_reset();
    dec_ebreak = 1; ifu_ack = 1;
    tick(); ifu_ack = 0;
    chk("ebk_c1_halt", halt, 0);
    tick();
    chk("ebk_halt", halt, 1);
    chk("ebk_state", state, 4);
    n = 0;
    for (int i = 0; i < 100; i++) begin
      ifu_ack = i[0]; lsu_ack = i[1];
      if (ifu_req | lsu_req | rf_we | csr_commit) n++;
      tick();
    end
    ifu_ack = 0; lsu_ack = 0;
    chk("ebk_quiet", n, 0);
    chk("ebk_halt_sticky", halt, 1);
    clr_dec();

    // Fetch timeout: ERROR after 8 ack-less FETCH cycles; a late ack is ignored
    do_reset();
    n = 0;
    while (state == 0 && n < 50) begin
      n++;
      tick();
    end
    chk("to_fetch_cycles", n, 8);
    chk("to_err", err, 1);
    ifu_ack = 1; ifu_rdata = 32'hDEAD_BEEF;
    tick(); ifu_ack = 0;
    chk("to_late_state", state, 5);
    chk("to_late_inst", inst, 32'h0000_0013);

    // Ack in the same cycle as the limit wins
    do_reset();
    for (int i = 0; i < 7; i++) tick();
    chk("lim_state_before", state, 0);
    ifu_ack = 1; ifu_rdata = 32'h0000_0013;
    tick(); ifu_ack = 0;
    chk("lim_exec", state, 1);
    tick(); tick();
    chk("lim_pc", pc, 32'h8000_0004);

    // Reset mid-MEM: request drops, pc reloads, nothing commits
    dec_is_store = 1; dec_rd_we = 1; ifu_ack = 1;
    tick(); ifu_ack = 0;
    tick();
    chk("rstm_lsureq", lsu_req, 1);
    rst = 1;
    tick();
    chk("rstm_lsureq_after", lsu_req, 0);
    chk("rstm_pc", pc, 32'h8000_0000);
    chk("rstm_commit", {rf_we, csr_commit}, 0);
    rst = 0;
    chk("rstm_state", state, 0);
    clr_dec();

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
